softmax_argmax_fifo: RTL and testbench

Classification back-end placed directly downstream of the two-class softmax stage. Each valid pair of IEEE-754 single-precision probabilities is compared, and the block produces a class index plus a confidence word. Results are buffered in a show-ahead FIFO with a ready/valid output handshake, and per-class and dropped-sample statistics are kept. The upstream softmax has no backpressure, so samples arriving while the FIFO is full are dropped and counted.

---
 rtl/softmax_argmax_fifo.sv | 126 ++++++++++++
 tb/tb_softmax_argmax_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/softmax_argmax_fifo.sv
// Two-class argmax back-end: float32 compare stage, show-ahead result FIFO with
// ready/valid output, and saturating per-class / drop statistics.
module softmax_argmax_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic [31:0]   p0,
  input  logic [31:0]   p1,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          class_id,
  output logic [31:0]   conf,
  output logic          nan_err,
  output logic          full,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] drop_cnt,
  output logic          overflow
);

  typedef struct packed {
    logic        nan;
    logic        cls;
    logic [31:0] conf;
  } entry_t;

  // True when a > b under IEEE-754 ordering; +0 and -0 are equal.
  function automatic logic float_gt(input logic [31:0] a, input logic [31:0] b);
    logic both_zero;
    both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    case ({a[31], b[31]})
      2'b00:   float_gt = a[30:0] > b[30:0];
      2'b11:   float_gt = a[30:0] < b[30:0];
      2'b01:   float_gt = !both_zero;
      default: float_gt = 1'b0;
    endcase
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Stage C: compare
  logic   cmp_v;
  entry_t cmp_e;
  entry_t cmp_next;

  always_comb begin
    cmp_next.nan  = is_nan(p0) || is_nan(p1);
    cmp_next.cls  = !cmp_next.nan && float_gt(p1, p0);
    cmp_next.conf = cmp_next.cls ? p1 : p0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmp_v <= 1'b0;
      cmp_e <= '0;
    end else begin
      cmp_v <= valid_in;
      if (valid_in) cmp_e <= cmp_next;
    end
  end

  // Stage W: FIFO write / pop / statistics
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop, push, drop;
  entry_t        head;

  assign out_valid = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop       = out_valid && out_ready;
  assign push      = cmp_v && (!full || pop);
  assign drop      = cmp_v && !push;

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are meaningful, and empty-FIFO head fields are forced to 0.
  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= cmp_e;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt0     <= '0;
      cnt1     <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push && !cmp_e.cls && cnt0 != '1) cnt0 <= cnt0 + 1'b1;
      if (push &&  cmp_e.cls && cnt1 != '1) cnt1 <= cnt1 + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  assign head     = mem[rd_ptr];
  assign class_id = out_valid && head.cls;
  assign nan_err  = out_valid && head.nan;
  assign conf     = out_valid ? head.conf : 32'd0;

endmodule

// File: tb/tb_softmax_argmax_fifo.sv
// Randomized plus directed bench for softmax_argmax_fifo, scored against a
// transaction-level model (result queue, pending-sample pipe, integer counters).
module tb_softmax_argmax_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [31:0]   p0, p1;
  logic          out_ready;
  logic          out_valid, class_id, nan_err, full, overflow;
  logic [31:0]   conf;
  logic [CW-1:0] cnt0, cnt1, drop_cnt;

  softmax_argmax_fifo #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .p0(p0), .p1(p1),
    .out_ready(out_ready), .out_valid(out_valid), .class_id(class_id),
    .conf(conf), .nan_err(nan_err), .full(full), .cnt0(cnt0), .cnt1(cnt1),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: results as {nan, class, conf}
  logic [33:0] q[$];
  logic        pend_v;
  logic [33:0] pend_e;
  int          m_cnt0, m_cnt1, m_drop;
  logic        m_ovf;
  localparam int SAT = (1 << CW) - 1;

  // Map a float to an unsigned key that sorts in numeric order.
  function automatic logic [31:0] sort_key(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic [33:0] classify(input logic [31:0] a, input logic [31:0] b);
    logic nan, cls;
    nan = ((a[30:23] == 8'hFF) && (a[22:0] != 0)) || ((b[30:23] == 8'hFF) && (b[22:0] != 0));
    if (nan) cls = 1'b0;
    else if (a[30:0] == 0 && b[30:0] == 0) cls = 1'b0;
    else cls = sort_key(b) > sort_key(a);
    return {nan, cls, cls ? b : a};
  endfunction

  task automatic model_reset();
    q.delete();
    pend_v = 1'b0;
    pend_e = '0;
    m_cnt0 = 0; m_cnt1 = 0; m_drop = 0; m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic rdy, input logic r);
    if (!r) begin
      model_reset();
      return;
    end
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (pend_v) begin
      if (q.size() < DEPTH) begin
        q.push_back(pend_e);
        if (pend_e[32]) begin if (m_cnt1 < SAT) m_cnt1++; end
        else            begin if (m_cnt0 < SAT) m_cnt0++; end
      end else begin
        if (m_drop < SAT) m_drop++;
        m_ovf = 1'b1;
      end
    end
    pend_v = v;
    pend_e = classify(a, b);
  endtask

  task automatic compare();
    check("out_valid", out_valid, q.size() != 0);
    check("full", full, q.size() == DEPTH);
    if (q.size() != 0) begin
      check("class_id", class_id, q[0][32]);
      check("conf", conf, q[0][31:0]);
      check("nan_err", nan_err, q[0][33]);
    end
    check("cnt0", cnt0, m_cnt0);
    check("cnt1", cnt1, m_cnt1);
    check("drop_cnt", drop_cnt, m_drop);
    check("overflow", overflow, m_ovf);
  endtask

  // One clock: check stable outputs, drive inputs, advance model, cross the edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic rdy, input logic r = 1'b1);
    compare();
    valid_in = v; p0 = a; p1 = b; out_ready = rdy; rst = r;
    model_edge(v, a, b, rdy, r);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, rdy);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7F80_0000;
      3:       return 32'hFF80_0000;
      4:       return {r[31], 8'hFF, r[22:1], 1'b1};
      5:       return {r[31], 8'h00, r[22:0]};
      6:       return {1'b0, 8'h7E, r[22:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b;
    logic        ready_bias;
    valid_in = 1'b0; p0 = '0; p1 = '0; out_ready = 1'b0; rst = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset held with valid_in toggling: everything stays at zero.
    step(1'b1, 32'h3F40_0000, 32'h3E80_0000, 1'b1, 1'b0);
    step(1'b0, 32'h3F40_0000, 32'h3E80_0000, 1'b1, 1'b0);
    step(1'b1, 32'h3F40_0000, 32'h3E80_0000, 1'b1, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_conf", conf, 32'h0);
    check("rst_class", class_id, 1'b0);
    check("rst_cnt0", cnt0, 32'h0);

    // First sample after release: visible two edges later, not consumed yet.
    step(1'b1, 32'h3F40_0000, 32'h3E80_0000, 1'b0);
    idle(2, 1'b0);
    check("first_conf", conf, 32'h3F40_0000);
    check("first_cnt0", cnt0, 32'd1);
    idle(2, 1'b1);

    // Ties, signed zeros, class-1 win, NaN.
    step(1'b1, 32'h3F00_0000, 32'h3F00_0000, 1'b0);
    step(1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0);
    step(1'b1, 32'h3DCC_CCCD, 32'h3F66_6666, 1'b0);
    step(1'b1, 32'h3F00_0000, 32'h7FC0_0000, 1'b0);
    idle(2, 1'b0);
    idle(5, 1'b1);

    // Overflow: six back-to-back samples into a stalled FIFO, then drain.
    for (int i = 0; i < 6; i++) step(1'b1, 32'h3F00_0000 + i, 32'h3E00_0000 + 32'(i * 2), 1'b0);
    idle(3, 1'b0);
    check("ovf_drop_cnt", drop_cnt, 32'd2);
    check("ovf_overflow", overflow, 1'b1);
    idle(6, 1'b1);

    // Push and pop on the same edge while full, across pointer wrap.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h3E00_0000, 32'h3F00_0000 + i, 1'b0);
    idle(2, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 32'h4000_0000 + i, 32'h3F00_0000, 1'b1);
    idle(6, 1'b1);

    // Mid-stream reset: the sample in the compare stage is lost.
    step(1'b1, 32'h3F00_0000, 32'h3F10_0000, 1'b0);
    step(1'b1, 32'h3F20_0000, 32'h3F10_0000, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h3F30_0000, 32'h3F10_0000, 1'b0);
    idle(3, 1'b0);
    idle(3, 1'b1);

    // Randomized traffic with varying backpressure and occasional reset.
    for (int blk = 0; blk < 20; blk++) begin
      ready_bias = blk[0];
      for (int i = 0; i < 100; i++) begin
        a = rand_fp();
        b = ($urandom_range(0, 7) == 0) ? a : rand_fp();
        step($urandom_range(0, 3) != 0, a, b,
             ready_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
             $urandom_range(0, 299) != 0);
      end
    end
    idle(8, 1'b1);
    compare();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
